// File: rtl/sync_fifo_pkg.sv
// Shared FIFO sizing defaults, derived widths and the data word type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sync_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int PTR_W          = $clog2(FIFO_DEPTH_DEF);
  localparam int CNT_W          = PTR_W + 1;

  typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Request/response bundle between a FIFO user and the sync_fifo storage.
// Latency: n/a (wiring only).
// Backpressure: n/a; the user watches full/empty and the status strobes.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF
);

  logic [WIDTH-1:0] data_in;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             almostfull;
  logic             empty;
  logic             almostempty;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;

  // The user side drives requests and observes data, flags and status.
  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, full, almostfull, empty, almostempty,
    input  wr_ack, overflow, underflow
  );

  // The FIFO side consumes requests and drives data, flags and status.
  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, full, almostfull, empty, almostempty,
    output wr_ack, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ctrl.sv
// Pointer/occupancy control: accept decisions, flag decode, per-request status.
// Latency: accepts are combinational; status strobes register one cycle later.
// Backpressure: writes refused while full, reads refused while empty.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PTR_BITS   = $clog2(FIFO_DEPTH),
  parameter int CNT_BITS   = PTR_BITS + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                rd_en,
  output logic                wr_accept,
  output logic                rd_accept,
  output logic [PTR_BITS-1:0] wr_ptr,
  output logic [PTR_BITS-1:0] rd_ptr,
  output logic                full,
  output logic                almostfull,
  output logic                empty,
  output logic                almostempty,
  output logic                wr_ack,
  output logic                overflow,
  output logic                underflow
);

  logic [CNT_BITS-1:0] count;
  logic [CNT_BITS-1:0] count_nxt;

  // Flags are straight decodes of the occupancy count.
  assign full        = (count == CNT_BITS'(FIFO_DEPTH));
  assign almostfull  = (count == CNT_BITS'(FIFO_DEPTH - 1));
  assign empty       = (count == '0);
  assign almostempty = (count == CNT_BITS'(1));

  // A full FIFO still takes a read, so a simultaneous write is the one refused;
  // an empty FIFO still takes a write, so the simultaneous read is refused.
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Occupancy moves only when exactly one side is accepted.
  always_comb begin
    count_nxt = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_nxt = count + CNT_BITS'(1);
      2'b01:   count_nxt = count - CNT_BITS'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers and count; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (rd_accept) rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count_nxt;
    end
  end

  // Per-request status reflects what happened to last cycle's requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_accept;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage array plus registered read data around the control block.
// Latency: read data appears the cycle after an accepted read; no write fall-through.
// Backpressure: full rejects writes (overflow), empty rejects reads (underflow).
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  sync_fifo_if.slave  bus
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] data_out_q;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;

  sync_fifo_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (bus.wr_en),
    .rd_en       (bus.rd_en),
    .wr_accept   (wr_accept),
    .rd_accept   (rd_accept),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .full        (bus.full),
    .almostfull  (bus.almostfull),
    .empty       (bus.empty),
    .almostempty (bus.almostempty),
    .wr_ack      (bus.wr_ack),
    .overflow    (bus.overflow),
    .underflow   (bus.underflow)
  );

  // Storage is not reset; only accepted writes land in the array.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= bus.data_in;
  end

  // Read register samples the pre-edge array, so a same-cycle write is never returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         data_out_q <= '0;
    else if (rd_accept) data_out_q <= mem[rd_ptr];
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed stimulus against a queue-based reference with a decoupled scoreboard.
// Latency: expectations are due on the negedge following the edge that applies a request.
// Backpressure: the model refuses writes at DEPTH entries and reads at zero entries.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int W = FIFO_WIDTH_DEF;
  localparam int D = FIFO_DEPTH_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sync_fifo_if #(.WIDTH(W)) bus ();

  sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  due;
    logic [W-1:0] dout;
    logic         wr_ack;
    logic         ovf;
    logic         udf;
    logic         full;
    logic         afull;
    logic         empty;
    logic         aempty;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model_q[$];
  logic [W-1:0] model_dout = '0;
  int           checks = 0;
  int           errors = 0;
  int unsigned  cyc = 0;
  exp_t         mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endfunction

  // Scoreboard: compare every expectation that has come due.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      check("data_out",    32'(bus.data_out),   32'(mon_e.dout));
      check("wr_ack",      32'(bus.wr_ack),     32'(mon_e.wr_ack));
      check("overflow",    32'(bus.overflow),   32'(mon_e.ovf));
      check("underflow",   32'(bus.underflow),  32'(mon_e.udf));
      check("full",        32'(bus.full),       32'(mon_e.full));
      check("almostfull",  32'(bus.almostfull), 32'(mon_e.afull));
      check("empty",       32'(bus.empty),      32'(mon_e.empty));
      check("almostempty", 32'(bus.almostempty),32'(mon_e.aempty));
    end
  end

  // Drive one request cycle and record what the reference says must follow it.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
    n = model_q.size();
    e.due    = cyc + 1;
    e.wr_ack = w && (n < D);
    e.ovf    = w && (n == D);
    e.udf    = r && (n == 0);
    if (r && n > 0) model_dout = model_q.pop_front();
    if (w && n < D) model_q.push_back(d);
    n = model_q.size();
    e.dout   = model_dout;
    e.full   = (n == D);
    e.afull  = (n == D - 1);
    e.empty  = (n == 0);
    e.aempty = (n == 1);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"},     32'(bus.empty),       32'd1);
    check({tag, "_full"},      32'(bus.full),        32'd0);
    check({tag, "_afull"},     32'(bus.almostfull),  32'd0);
    check({tag, "_aempty"},    32'(bus.almostempty), 32'd0);
    check({tag, "_data_out"},  32'(bus.data_out),    32'd0);
    check({tag, "_wr_ack"},    32'(bus.wr_ack),      32'd0);
    check({tag, "_overflow"},  32'(bus.overflow),    32'd0);
    check({tag, "_underflow"}, 32'(bus.underflow),   32'd0);
  endtask

  // Let the last request land and be scored, then reset between edges.
  task automatic mid_reset();
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    model_q.delete();
    model_dout = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pw [6] = '{80, 20, 50, 95, 5, 50};
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = '0;

    repeat (2) @(posedge clk);
    #2;
    check_reset_state("init");
    #1;
    rst_n = 1'b1;

    repeat (3) step(1'b0, 1'b0, '0);

    for (int i = 1; i <= D; i++) step(1'b1, 1'b0, W'(i));
    step(1'b1, 1'b0, 16'hFFFF);
    repeat (D + 1) step(1'b0, 1'b1, '0);

    step(1'b1, 1'b1, 16'hABCD);
    step(1'b0, 1'b1, '0);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, W'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, W'($urandom));
    repeat (4) step(1'b0, 1'b1, '0);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'($urandom));
    mid_reset();
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b1, '0);

    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(0, 99) < pw[b],
             $urandom_range(0, 99) < (100 - pw[b]),
             W'($urandom));
      end
    end

    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Synchronous single-clock FIFO: the design under test whose interface signals the FIFO monitor samples on every negedge of clk.
- Buffers FIFO_WIDTH-bit words.
- Reports occupancy flags (full, almostfull, empty, almostempty).
- Reports per-request status (wr_ack, overflow, underflow) so the scoreboard and coverage can check every transaction.

Parameters:
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 8, number of storage entries; power of two, >= 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; single clock domain.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  registered read data.
- full  output  1  count == FIFO_DEPTH (combinational from count).
- almostfull  output  1  count == FIFO_DEPTH-1 (combinational).
- empty  output  1  count == 0 (combinational).
- almostempty  output  1  count == 1 (combinational).
- wr_ack  output  1  registered; previous-cycle write accepted.
- overflow  output  1  registered; previous-cycle write rejected because full.
- underflow  output  1  registered; previous-cycle read rejected because empty.

Behaviour:
- State:
  - wr_ptr, rd_ptr: $clog2(FIFO_DEPTH) bits each, natural wrap from DEPTH-1 to 0.
  - count: $clog2(FIFO_DEPTH)+1 bits.
  - mem[FIFO_DEPTH].
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = count = 0.
  - data_out = 0, wr_ack = overflow = underflow = 0.
  - Consequently empty = 1, full = almostfull = almostempty = 0.
  - mem contents are not reset.
  - Reset mid-operation discards all stored data immediately; no partial update on the edge where reset deasserts.
- Write accepted (wr_en && !full):
  - mem[wr_ptr] <= data_in, wr_ptr+1, wr_ack <= 1, overflow <= 0.
- Write rejected (wr_en && full):
  - mem and wr_ptr unchanged, wr_ack <= 0, overflow <= 1.
- No write request (!wr_en): wr_ack <= 0, overflow <= 0.
- Read accepted (rd_en && !empty):
  - data_out <= mem[rd_ptr], rd_ptr+1, underflow <= 0.
  - Latency: data visible the cycle after the request edge.
- Read rejected (rd_en && empty): data_out holds its previous value, underflow <= 1.
- No read request (!rd_en): data_out holds, underflow <= 0.
- Count update (same edge):
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged when both accepted or neither accepted.
- Simultaneous wr_en && rd_en:
  - Empty: write accepted, read rejected (underflow=1); count 0 -> 1. No fall-through: data_out does not take data_in.
  - Full: read accepted, write rejected (overflow=1); count DEPTH -> DEPTH-1.
  - Otherwise: both accepted; count unchanged; read returns the oldest entry, never the word being written.
- Flags are pure decodes of count: no glitch-free requirement, but they must be stable before the negedge.
- Invariants:
  - count never exceeds FIFO_DEPTH and never underflows.
  - full and empty are never both 1.
  - count == (wr_ptr - rd_ptr) mod DEPTH, except count == DEPTH when the pointers are equal.

Decomposition:
- fifo_pkg: FIFO_WIDTH/FIFO_DEPTH defaults, derived localparams PTR_W = $clog2(FIFO_DEPTH) and CNT_W = PTR_W+1, and typedef fifo_word_t. The same package is shared with the transaction, scoreboard and reference model.
- One sub-module: sync_fifo_ctrl. It owns the pointers, count, accept/reject decisions and flag decode, and exports wr_accept, rd_accept, wr_ptr and rd_ptr.
- Storage array and data_out register stay in sync_fifo.

Test Plan:
- Reset then idle 3 cycles -> empty=1, data_out=0, wr_ack=overflow=underflow=0.
- Write 0x0001..0x0008 (DEPTH=8) -> wr_ack=1 after each; almostfull=1 after the 7th, full=1 after the 8th. A 9th write of 0xFFFF -> overflow=1, wr_ack=0, contents unchanged.
- Read 8 times from full -> data_out 0x0001..0x0008 in order, one cycle after each rd_en; almostempty=1 when count=1, then empty=1. A 9th read -> underflow=1, data_out stays 0x0008.
- wr_en=rd_en=1 with data_in=0xABCD while empty -> count=1, underflow=1, wr_ack=1. The next read returns 0xABCD.
- Wrap-around: with 4 entries resident, stream 20 cycles of simultaneous write/read -> count stays 4, output order matches input order across pointer wrap, no overflow/underflow.
- Assert rst_n low while count=5 in mid-stream -> flags immediately show empty=1, count=0. After release, the first read gives underflow=1 and the first write is acked.
